// File: rtl/counter_ctrl_pkg.sv
// rtl/counter_ctrl_pkg.sv - shared encodings and defaults for the counter sequencing controller
package counter_ctrl_pkg;

    localparam int CNT_W_DEF = 4;
    localparam int DIV_W_DEF = 8;
    localparam int IO_W_DEF  = 8;

    typedef enum logic [1:0] {
        OP_STOP    = 2'b00,
        OP_RUN     = 2'b01,
        OP_LOAD    = 2'b10,
        OP_ONESHOT = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        ONESHOT = 2'b10,
        LOAD    = 2'b11
    } state_e;

    function automatic logic is_count_op(input op_e op);
        return (op == OP_RUN) || (op == OP_ONESHOT);
    endfunction

endpackage

// File: rtl/counter_prescaler.sv
// rtl/counter_prescaler.sv - programmable divider producing the registered counter step strobe
module counter_prescaler #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             halt,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             cnt_en
);

    logic [DIV_W-1:0] pcnt_q, pcnt_d;
    logic             en_q, en_d;

    assign tick   = enable && !clear && (pcnt_q == div);
    assign cnt_en = en_q;

    // Anything other than an uninterrupted count mode parks the divider at zero.
    always_comb begin
        pcnt_d = '0;
        en_d   = 1'b0;
        if (enable && !clear) begin
            if (pcnt_q == div) begin
                pcnt_d = '0;
                en_d   = !halt;
            end else begin
                pcnt_d = pcnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt_q <= '0;
            en_q   <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            en_q   <= en_d;
        end
    end

endmodule

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - command-driven run/stop/load/one-shot sequencer for the project counter
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DIV_W = DIV_W_DEF,
    parameter int IO_W  = IO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_dir,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic [CNT_W-1:0] cmd_data,
    input  logic [CNT_W-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_val,
    output logic             busy,
    output logic             done,
    output logic [IO_W-1:0]  io_oeb
);

    state_e           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             up_q, up_d;
    logic             load_q, load_d;
    logic [CNT_W-1:0] load_val_q, load_val_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             started_q, started_d;

    op_e              op;
    logic             cmd_fire;
    logic             counting;
    logic             tick;
    logic             finish;
    logic [CNT_W-1:0] nxt;
    logic [CNT_W-1:0] terminal;

    assign op        = op_e'(cmd_op);
    assign cmd_ready = (state_q != LOAD);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign counting  = (state_q == RUN) || (state_q == ONESHOT);

    counter_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .clear  (cmd_fire && is_count_op(op)),
        .enable (counting && !cmd_fire),
        .halt   (finish),
        .div    (div_q),
        .tick   (tick),
        .cnt_en (cnt_en)
    );

    // Look at where the counter will sit after this edge, including a step already in flight.
    assign nxt      = cnt_en ? (up_q ? cnt_value + CNT_W'(1) : cnt_value - CNT_W'(1)) : cnt_value;
    assign terminal = up_q ? {CNT_W{1'b1}} : {CNT_W{1'b0}};
    assign finish   = (state_q == ONESHOT) && tick && (nxt == terminal);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        up_d       = up_q;
        load_d     = 1'b0;
        load_val_d = load_val_q;
        done_d     = 1'b0;
        started_d  = started_q;
        if (state_q == LOAD) begin
            state_d = IDLE;
        end
        if (cmd_fire) begin
            unique case (op)
                OP_STOP: state_d = IDLE;
                OP_RUN, OP_ONESHOT: begin
                    state_d   = (op == OP_RUN) ? RUN : ONESHOT;
                    div_d     = cmd_div;
                    up_d      = cmd_dir;
                    started_d = 1'b1;
                end
                OP_LOAD: begin
                    state_d    = LOAD;
                    load_d     = 1'b1;
                    load_val_d = cmd_data;
                    started_d  = 1'b1;
                end
                default: state_d = IDLE;
            endcase
        end else if (finish) begin
            state_d = IDLE;
            done_d  = 1'b1;
        end
        busy_d = (state_d == RUN) || (state_d == ONESHOT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_q      <= '0;
            up_q       <= 1'b1;
            load_q     <= 1'b0;
            load_val_q <= '0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            up_q       <= up_d;
            load_q     <= load_d;
            load_val_q <= load_val_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
            started_q  <= started_d;
        end
    end

    assign cnt_up       = up_q;
    assign cnt_load     = load_q;
    assign cnt_load_val = load_val_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign io_oeb       = {{(IO_W-CNT_W){1'b1}}, {CNT_W{~started_q}}};

endmodule

// File: tb/tb_counter_ctrl.sv
// tb/tb_counter_ctrl.sv - self-checking bench for counter_ctrl driving a behavioural 4-bit counter
module tb_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic       cmd_dir;
    logic [7:0] cmd_div;
    logic [3:0] cmd_data;
    logic [3:0] cnt = 4'd0;
    logic       cnt_en, cnt_up, cnt_load, busy, done;
    logic [3:0] cnt_load_val;
    logic [7:0] io_oeb;

    int total = 0;
    int passed = 0;
    bit chk_on = 1'b0;
    int en_total = 0;
    int done_total = 0;

    // reference model state: mode 0 idle, 1 run, 2 oneshot, 3 load
    int       m_mode = 0;
    int       m_age = 0;
    int       m_div = 0;
    bit       m_dir = 1'b1;
    bit       m_en = 1'b0;
    bit       m_load = 1'b0;
    int       m_lval = 0;
    bit       m_done = 1'b0;
    bit       m_started = 1'b0;

    always #5 clk = ~clk;

    counter_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_dir      (cmd_dir),
        .cmd_div      (cmd_div),
        .cmd_data     (cmd_data),
        .cnt_value    (cnt),
        .cnt_en       (cnt_en),
        .cnt_up       (cnt_up),
        .cnt_load     (cnt_load),
        .cnt_load_val (cnt_load_val),
        .busy         (busy),
        .done         (done),
        .io_oeb       (io_oeb)
    );

    always @(posedge clk) begin
        if (cnt_load) cnt <= cnt_load_val;
        else if (cnt_en) cnt <= cnt_up ? cnt + 4'd1 : cnt - 4'd1;
    end

    always @(posedge clk) begin : model
        int  n_mode, n_age, n_div, n_lval, nxt;
        bit  n_dir, n_en, n_load, n_done, n_started, tick;
        n_mode = m_mode; n_age = m_age; n_div = m_div; n_dir = m_dir; n_en = m_en;
        n_load = 1'b0; n_lval = m_lval; n_done = 1'b0; n_started = m_started;
        if (rst) begin
            n_mode = 0; n_age = 0; n_div = 0; n_dir = 1'b1; n_en = 1'b0;
            n_lval = 0; n_started = 1'b0;
        end else begin
            if (m_mode == 3) n_mode = 0;
            if (cmd_valid && m_mode != 3) begin
                n_en = 1'b0;
                case (cmd_op)
                    2'd0: n_mode = 0;
                    2'd2: begin n_mode = 3; n_load = 1'b1; n_lval = int'(cmd_data); n_started = 1'b1; end
                    default: begin
                        n_mode = (cmd_op == 2'd1) ? 1 : 2;
                        n_div = int'(cmd_div); n_dir = cmd_dir; n_age = 0; n_started = 1'b1;
                    end
                endcase
            end else if (m_mode == 1 || m_mode == 2) begin
                n_age = m_age + 1;
                tick  = (n_age % (m_div + 1)) == 0;
                nxt   = m_en ? (m_dir ? (int'(cnt) + 1) % 16 : (int'(cnt) + 15) % 16) : int'(cnt);
                if (tick && m_mode == 2 && nxt == (m_dir ? 15 : 0)) begin
                    n_en = 1'b0; n_mode = 0; n_done = 1'b1;
                end else begin
                    n_en = tick;
                end
            end else begin
                n_en = 1'b0;
            end
        end
        m_mode <= n_mode; m_age <= n_age; m_div <= n_div; m_dir <= n_dir; m_en <= n_en;
        m_load <= n_load; m_lval <= n_lval; m_done <= n_done; m_started <= n_started;
    end

    always @(posedge clk) begin
        #2;
        if (cnt_en === 1'b1) en_total++;
        if (done === 1'b1) done_total++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("cnt_en", 32'(cnt_en), 32'(m_en));
            chk("cnt_up", 32'(cnt_up), 32'(m_dir));
            chk("cnt_load", 32'(cnt_load), 32'(m_load));
            chk("cnt_load_val", 32'(cnt_load_val), 32'(m_lval));
            chk("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
            chk("done", 32'(done), 32'(m_done));
            chk("cmd_ready", 32'(cmd_ready), 32'(m_mode != 3));
            chk("io_oeb", 32'(io_oeb), m_started ? 32'hF0 : 32'hFF);
        end
    end

    task automatic issue(input logic [1:0] op, input logic dir, input logic [7:0] div, input logic [3:0] data);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dir = dir; cmd_div = div; cmd_data = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int en0, d0, c0, i;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_dir = 1'b0; cmd_div = 8'd0; cmd_data = 4'd0;
        @(negedge clk);
        chk_on = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cnt_en", 32'(cnt_en), 32'd0);
        chk("rst_cnt_load", 32'(cnt_load), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_io_oeb", 32'(io_oeb), 32'hFF);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        rst = 1'b0;

        // RUN up, divisor 0, from 0: 17 steps wrap the counter to 1
        en0 = en_total; d0 = done_total;
        issue(2'd1, 1'b1, 8'd0, 4'd0);
        repeat (18) @(negedge clk);
        chk("run0_cnt", 32'(cnt), 32'd1);
        chk("run0_en_cycles", 32'(en_total - en0), 32'd18);
        chk("run0_no_done", 32'(done_total - d0), 32'd0);
        chk("run0_io_oeb", 32'(io_oeb), 32'hF0);

        // RUN with divisor 3 restarts the prescaler
        issue(2'd1, 1'b1, 8'd3, 4'd0);
        c0 = int'(cnt); en0 = en_total;
        repeat (12) @(negedge clk);
        chk("run3_en_cycles", 32'(en_total - en0), 32'd3);
        chk("run3_cnt", 32'(cnt), 32'((c0 + 2) % 16));
        issue(2'd0, 1'b0, 8'd0, 4'd0);
        chk("stop_cnt_en", 32'(cnt_en), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        c0 = int'(cnt);
        repeat (6) @(negedge clk);
        chk("stop_hold", 32'(cnt), 32'(c0));

        // LOAD 5 then ONESHOT down with divisor 1
        issue(2'd2, 1'b0, 8'd0, 4'd5);
        chk("load_strobe", 32'(cnt_load), 32'd1);
        chk("load_val", 32'(cnt_load_val), 32'd5);
        chk("load_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        chk("load_cnt", 32'(cnt), 32'd5);
        chk("load_strobe_off", 32'(cnt_load), 32'd0);
        en0 = en_total; d0 = done_total;
        issue(2'd3, 1'b0, 8'd1, 4'd0);
        repeat (20) @(negedge clk);
        chk("os_dn_cnt", 32'(cnt), 32'd0);
        chk("os_dn_en_cycles", 32'(en_total - en0), 32'd5);
        chk("os_dn_done", 32'(done_total - d0), 32'd1);
        chk("os_dn_busy", 32'(busy), 32'd0);

        // ONESHOT up from 13 halts at 15
        issue(2'd2, 1'b0, 8'd0, 4'd13);
        en0 = en_total; d0 = done_total;
        issue(2'd3, 1'b1, 8'd0, 4'd0);
        repeat (8) @(negedge clk);
        chk("os_up_cnt", 32'(cnt), 32'd15);
        chk("os_up_en_cycles", 32'(en_total - en0), 32'd2);
        chk("os_up_done", 32'(done_total - d0), 32'd1);

        // reset in the middle of a ONESHOT with a command presented alongside
        issue(2'd2, 1'b0, 8'd0, 4'd8);
        issue(2'd3, 1'b0, 8'd0, 4'd0);
        i = 0;
        while (cnt != 4'd3 && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("reach_3", 32'(cnt), 32'd3);
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1; cmd_dir = 1'b1; cmd_div = 8'd0;
        @(negedge clk);
        chk("mid_rst_cnt_en", 32'(cnt_en), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_io_oeb", 32'(io_oeb), 32'hFF);
        chk("mid_rst_cnt_up", 32'(cnt_up), 32'd1);
        c0 = int'(cnt);
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_hold", 32'(cnt), 32'(c0));
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
